// File: rtl/count_seq_checker.sv
// count_seq_checker: watches a free-running up-counter bus and checks every
// valid sample is the previous sample + 1 (mod 2^WIDTH).
// Ports: clk, reset (async active-low), value_in/valid_in (observed counter),
//   clr_in (counter's own sync clear), locked, err_pulse, err_count,
//   expected (next expected value), wrap_pulse (good all-ones -> 0 step).
// Option COUNT_SEQ_CHECKER_WRAP_CNT_EN adds wrap_count[15:0] (reset-only clear).
module count_seq_checker #(
   parameter int unsigned WIDTH    = 6,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] value_in,
   input  logic             valid_in,
   input  logic             clr_in,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] expected,
`ifdef COUNT_SEQ_CHECKER_WRAP_CNT_EN
   output logic             wrap_pulse,
   output logic [15:0]      wrap_count
`else
   output logic             wrap_pulse
`endif
);

   typedef enum logic [1:0] {
      HUNT,
      TRACK,
      LOCKED
   } state_t;

   localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);

   state_t           state_q, state_d;
   logic [7:0]       run_q, run_d;
   logic [WIDTH-1:0] exp_d;
   logic [ERR_W-1:0] errc_d;
   logic             locked_d, errp_d, wrapp_d;
   logic             match;

   assign match = (value_in == expected);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= HUNT;
         run_q      <= '0;
         expected   <= '0;
         err_count  <= '0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         wrap_pulse <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         expected   <= exp_d;
         err_count  <= errc_d;
         locked     <= locked_d;
         err_pulse  <= errp_d;
         wrap_pulse <= wrapp_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      exp_d    = expected;
      errc_d   = err_count;
      locked_d = locked;
      errp_d   = 1'b0;
      wrapp_d  = 1'b0;
      if (clr_in) begin
         state_d  = HUNT;
         run_d    = '0;
         locked_d = 1'b0;
      end else if (valid_in) begin
         // every valid sample becomes the new reference
         exp_d = value_in + 1'b1;
         unique case (state_q)
            HUNT: begin
               state_d = TRACK;
               run_d   = '0;
            end
            TRACK: begin
               if (match) begin
                  run_d   = run_q + 8'd1;
                  // matching 0 implies the previous sample was all-ones
                  wrapp_d = (value_in == '0);
                  if (run_q + 8'd1 >= LOCK_N) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  run_d = '0;
               end
            end
            LOCKED: begin
               if (match) begin
                  wrapp_d = (value_in == '0);
               end else begin
                  errp_d   = 1'b1;
                  locked_d = 1'b0;
                  run_d    = '0;
                  state_d  = TRACK;
                  if (err_count != '1)
                     errc_d = err_count + 1'b1;
               end
            end
            default: begin
               state_d  = HUNT;
               run_d    = '0;
               locked_d = 1'b0;
            end
         endcase
      end
   end

`ifdef COUNT_SEQ_CHECKER_WRAP_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wrap_count <= '0;
      else if (wrapp_d)
         wrap_count <= wrap_count + 16'd1;
   end
`endif

endmodule
